// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fp_pkg
//  Description : Shared widths, state encoding and constants for the FP
//                multiply datapath (normalizer/rounder and downstream stages).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_BIAS  = 127;

    // Significand width including the hidden bit
    function automatic int fp_sig_w(input int data_w);
        return data_w - FP_EXP_W;
    endfunction

    // Stored fraction width (hidden bit excluded)
    function automatic int fp_frac_w(input int data_w);
        return data_w - FP_EXP_W - 1;
    endfunction

    // Double-width significand product
    function automatic int fp_prod_w(input int data_w);
        return 2 * (data_w - FP_EXP_W);
    endfunction

    // Width of a shift count across the product
    function automatic int fp_lzc_w(input int data_w);
        return $clog2(2 * (data_w - FP_EXP_W));
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_state_e;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/lz_step_enc.sv
`default_nettype none
// ============================================================================
//  Module      : lz_step_enc
//  Description : Combinational leading-zero priority encoder over a W-bit
//                window; returns W when the window is all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lz_step_enc #(
    parameter int W = 4
) (
    input  logic [W-1:0]           i_win,
    output logic [$clog2(W+1)-1:0] o_lz
);

    localparam int CW = $clog2(W + 1);

    // Scan upward so the highest set bit wins the last assignment
    always_comb begin
        o_lz = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_win[i]) begin
                o_lz = CW'(W - 1 - i);
            end
        end
    end

endmodule : lz_step_enc
`default_nettype wire

// File: rtl/fp_mant_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mant_norm_round
//  Description : Multi-cycle significand normalizer and round-to-nearest-even
//                stage of the FP multiplier. Shifts left up to SHIFT_STEP bits
//                per cycle, capped by the temporary exponent, then rounds.
//                Optional macro FP_NORM_INEXACT_EN adds the 'inexact' output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mant_norm_round
    import fp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [fp_prod_w(DATA_W)-1:0]  mant_raw,
    input  logic [FP_EXP_W-1:0]           exp_res_tmp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [fp_frac_w(DATA_W)-1:0]  mant_fin,
    output logic                          exp_incr,
    output logic                          mant_overfl,
    output logic                          not_full_norm,
    output logic [fp_lzc_w(DATA_W)-1:0]   leading_zero_num,
    output logic                          zero_res
`ifdef FP_NORM_INEXACT_EN
    ,
    output logic                          inexact
`endif
);

    localparam int MW      = fp_frac_w(DATA_W);
    localparam int P       = fp_prod_w(DATA_W);
    localparam int LZW     = fp_lzc_w(DATA_W);
    localparam int CAP_MAX = P - 2;
    localparam int SW      = $clog2(SHIFT_STEP + 1);

    fp_state_e          r_state, w_state_nxt;
    logic [P-1:0]       r_sh;
    logic [LZW-1:0]     r_cap, r_cnt;
    logic [MW-1:0]      r_mant_fin;
    logic               r_exp_incr, r_mant_overfl, r_not_full_norm, r_zero_res;
    logic [LZW-1:0]     r_lzn;
`ifdef FP_NORM_INEXACT_EN
    logic               r_inexact;
`endif

    logic [LZW-1:0]     w_cap_in, w_rem, w_lz_ext, w_step, w_cnt_nxt;
    logic [SW-1:0]      w_lz;
    logic [P-1:0]       w_sh_shift;
    logic               w_start_norm, w_norm_done;
    logic [MW-1:0]      w_frac;
    logic               w_guard, w_sticky, w_round_up;
    logic [MW:0]        w_sum;

    // Shift cap is the exponent, saturated so the leading one stays in range
    assign w_cap_in     = (int'(exp_res_tmp) > CAP_MAX) ? LZW'(CAP_MAX) : LZW'(exp_res_tmp);
    assign w_start_norm = (mant_raw[P-1:P-2] == 2'b00) && (|mant_raw) && (w_cap_in != '0);

    lz_step_enc #(
        .W (SHIFT_STEP)
    ) u_lz_step_enc (
        .i_win (r_sh[P-2 -: SHIFT_STEP]),
        .o_lz  (w_lz)
    );

    assign w_rem       = r_cap - r_cnt;
    assign w_lz_ext    = LZW'(w_lz);
    assign w_step      = (w_lz_ext < w_rem) ? w_lz_ext : w_rem;
    assign w_sh_shift  = r_sh << w_step;
    assign w_cnt_nxt   = r_cnt + w_step;
    assign w_norm_done = w_sh_shift[P-2] || (w_cnt_nxt == r_cap);

    // Select fraction/guard/sticky below the leading-one position
    always_comb begin
        if (r_exp_incr) begin
            w_frac   = r_sh[P-2 -: MW];
            w_guard  = r_sh[P-2-MW];
            w_sticky = |r_sh[P-3-MW:0];
        end else begin
            w_frac   = r_sh[P-3 -: MW];
            w_guard  = r_sh[P-3-MW];
            w_sticky = |r_sh[P-4-MW:0];
        end
    end

    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_sum      = {1'b0, w_frac} + (MW+1)'(w_round_up);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = w_start_norm ? NORM : ROUND;
            NORM:    if (w_norm_done) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift in NORM, register results in ROUND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh            <= '0;
            r_cap           <= '0;
            r_cnt           <= '0;
            r_mant_fin      <= '0;
            r_exp_incr      <= 1'b0;
            r_mant_overfl   <= 1'b0;
            r_not_full_norm <= 1'b0;
            r_lzn           <= '0;
            r_zero_res      <= 1'b0;
`ifdef FP_NORM_INEXACT_EN
            r_inexact       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh       <= mant_raw;
                        r_cap      <= w_cap_in;
                        r_cnt      <= '0;
                        r_exp_incr <= mant_raw[P-1];
                        r_zero_res <= ~|mant_raw;
                    end
                end
                NORM: begin
                    r_sh  <= w_sh_shift;
                    r_cnt <= w_cnt_nxt;
                end
                ROUND: begin
                    r_mant_fin      <= w_sum[MW-1:0];
                    r_mant_overfl   <= w_sum[MW];
                    r_lzn           <= r_cnt;
                    r_not_full_norm <= |r_cnt;
`ifdef FP_NORM_INEXACT_EN
                    r_inexact       <= w_guard | w_sticky;
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready         = (r_state == IDLE);
    assign out_valid        = (r_state == DONE);
    assign mant_fin         = r_mant_fin;
    assign exp_incr         = r_exp_incr;
    assign mant_overfl      = r_mant_overfl;
    assign not_full_norm    = r_not_full_norm;
    assign leading_zero_num = r_lzn;
    assign zero_res         = r_zero_res;
`ifdef FP_NORM_INEXACT_EN
    assign inexact          = r_inexact;
`endif

endmodule : fp_mant_norm_round
`default_nettype wire
